// File: rtl/sweep_dds.sv
// Linear-frequency-sweep phase generator. The FCW steps from f_start to f_stop and is held
// for a programmable dwell per value. The top accumulator bits address the waveform ROM.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no sweep; acc and fcw held at 0, waiting for start
// ST_SWEEP | accumulating phase, stepping fcw on each dwell terminal count
module sweep_dds #(
   parameter int ACC_W   = 32,
   parameter int ADDR_W  = 14,
   parameter int DWELL_W = 16
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [1:0]         mode,
   input  logic [ACC_W-1:0]   f_start,
   input  logic [ACC_W-1:0]   f_stop,
   input  logic [ACC_W-1:0]   f_step,
   input  logic [DWELL_W-1:0] dwell,
   output logic [ADDR_W-1:0]  addr,
   output logic [ACC_W-1:0]   fcw,
   output logic               busy,
   output logic               sweep_done,
   output logic               wrap
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;

   localparam logic [1:0] MODE_SINGLE = 2'd0;
   localparam logic [1:0] MODE_REPEAT = 2'd1;
   localparam logic [1:0] MODE_TRI    = 2'd2;
   localparam logic [1:0] MODE_RSVD   = 2'd3;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   fcw_q, fcw_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wrap_q, wrap_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic               dir_q, dir_d;

   // Latched sweep configuration (effective values after the 0 -> 1 and clamp rules)
   logic [1:0]         mode_q, mode_d;
   logic [ACC_W-1:0]   start_q, start_d;
   logic [ACC_W-1:0]   stop_q, stop_d;
   logic [ACC_W-1:0]   step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;

   logic [ACC_W:0]     up_sum;
   logic [ACC_W:0]     down_floor;
   logic [ACC_W-1:0]   up_next;
   logic [ACC_W-1:0]   down_next;
   logic               step_evt;

   // Sums are one bit wider so clamping never sees a wrapped value
   always_comb begin
      up_sum     = {1'b0, fcw_q} + {1'b0, step_q};
      down_floor = {1'b0, start_q} + {1'b0, step_q};
      up_next    = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[ACC_W-1:0];
      down_next  = ({1'b0, fcw_q} <= down_floor) ? start_q : (fcw_q - step_q);
      step_evt   = (dwell_cnt_q == (dwell_q - DWELL_W'(1)));
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      fcw_d       = fcw_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      wrap_d      = 1'b0;
      dwell_cnt_d = dwell_cnt_q;
      dir_d       = dir_q;
      mode_d      = mode_q;
      start_d     = start_q;
      stop_d      = stop_q;
      step_d      = step_q;
      dwell_d     = dwell_q;

      case (state_q)
         ST_IDLE: begin
            acc_d = '0;
            fcw_d = '0;
            if (start) begin
               mode_d      = (mode == MODE_RSVD) ? MODE_SINGLE : mode;
               start_d     = f_start;
               stop_d      = (f_start >= f_stop) ? f_start : f_stop;
               step_d      = (f_step == '0) ? ACC_W'(1) : f_step;
               dwell_d     = (dwell == '0) ? DWELL_W'(1) : dwell;
               fcw_d       = f_start;
               acc_d       = '0;
               dwell_cnt_d = '0;
               dir_d       = DIR_UP;
               busy_d      = 1'b1;
               state_d     = ST_SWEEP;
            end
         end

         ST_SWEEP: begin
            acc_d = acc_q + fcw_q;
            if (!step_evt) begin
               dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end else begin
               dwell_cnt_d = '0;
               if (dir_q == DIR_UP) begin
                  if (fcw_q < stop_q) begin
                     fcw_d = up_next;
                  end else begin
                     case (mode_q)
                        MODE_REPEAT: begin
                           fcw_d  = start_q;
                           wrap_d = 1'b1;
                        end
                        MODE_TRI: begin
                           dir_d  = DIR_DOWN;
                           fcw_d  = down_next;
                           wrap_d = (start_q == stop_q);
                        end
                        default: begin
                           state_d     = ST_IDLE;
                           busy_d      = 1'b0;
                           fcw_d       = '0;
                           acc_d       = '0;
                           dwell_cnt_d = '0;
                           done_d      = 1'b1;
                        end
                     endcase
                  end
               end else begin
                  if (fcw_q > start_q) begin
                     fcw_d = down_next;
                  end else begin
                     dir_d  = DIR_UP;
                     fcw_d  = up_next;
                     wrap_d = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            acc_d   = '0;
            fcw_d   = '0;
         end
      endcase

      // Abort wins over everything, including a start in the same cycle
      if (stop) begin
         state_d     = ST_IDLE;
         acc_d       = '0;
         fcw_d       = '0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         wrap_d      = 1'b0;
         dwell_cnt_d = '0;
         dir_d       = DIR_UP;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         fcw_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         dwell_cnt_q <= '0;
         dir_q       <= DIR_UP;
         mode_q      <= MODE_SINGLE;
         start_q     <= '0;
         stop_q      <= '0;
         step_q      <= ACC_W'(1);
         dwell_q     <= DWELL_W'(1);
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         fcw_q       <= fcw_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wrap_q      <= wrap_d;
         dwell_cnt_q <= dwell_cnt_d;
         dir_q       <= dir_d;
         mode_q      <= mode_d;
         start_q     <= start_d;
         stop_q      <= stop_d;
         step_q      <= step_d;
         dwell_q     <= dwell_d;
      end
   end

   assign addr       = acc_q[ACC_W-1 -: ADDR_W];
   assign fcw        = fcw_q;
   assign busy       = busy_q;
   assign sweep_done = done_q;
   assign wrap       = wrap_q;

endmodule

// File: doc/sweep_dds.md
Name: sweep_dds

Overview:
Parametrised linear-frequency-sweep phase generator; successor to the fixed-rate DDS address counter.
- Steps a frequency control word (FCW) from a start value to a stop value, holding each value for a programmable number of clocks.
- Accumulates phase each cycle and outputs the top phase bits as the waveform ROM address.
- Supports single, repeating (sawtooth) and triangle (up/down) sweeps, with start/abort control and status pulses. Sits between control logic and the waveform ROM.

Parameters:
ACC_W, 32, phase accumulator and FCW width
ADDR_W, 14, ROM address width; ADDR_W <= ACC_W
DWELL_W, 16, dwell counter width

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start request
stop  in  1  one-cycle abort request
mode  in  2  0 single up, 1 repeat up, 2 triangle, 3 treated as 0
f_start  in  ACC_W  first FCW
f_stop  in  ACC_W  last FCW
f_step  in  ACC_W  FCW increment; 0 treated as 1
dwell  in  DWELL_W  clocks per FCW value; 0 treated as 1
addr  out  ADDR_W  acc[ACC_W-1 -: ADDR_W], ROM address
fcw  out  ACC_W  current FCW
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse at end of single sweep
wrap  out  1  one-cycle pulse at each sweep period restart (repeat/triangle)

Behaviour:
Reset:
- Asynchronous on sys_rst_n low: state IDLE; acc, fcw, addr, busy, sweep_done, wrap, dwell_cnt, dir all 0.

States: IDLE, SWEEP.
- IDLE: acc and fcw are 0. Start on the start edge:
  - Latch mode, f_start, f_stop, f_step, dwell.
  - fcw <= f_start; acc <= 0; dwell_cnt <= 0; dir <= up; busy <= 1; state <= SWEEP.
- Config inputs are ignored after latching; start while busy is ignored.
- stop has priority: stop in any state → IDLE next edge with acc=0, fcw=0, busy=0, no sweep_done. Start and stop in the same cycle → remain/enter IDLE.

SWEEP, every cycle:
- acc <= acc + fcw, modulo 2^ACC_W.
- dwell_cnt increments. When dwell_cnt == dwell_eff-1, a step event fires and dwell_cnt <= 0. Each FCW value is therefore held exactly dwell_eff cycles.

Step event, dir up:
- fcw < f_stop: fcw <= min(fcw+step, f_stop). The sum is computed ACC_W+1 bits wide, so there is no overflow wrap.
- fcw == f_stop:
  - mode 0: state <= IDLE, busy <= 0, fcw <= 0, acc <= 0, sweep_done pulses 1 cycle.
  - mode 1: fcw <= f_start, wrap pulses.
  - mode 2: dir <= down, fcw <= max(f_stop-step, f_start) computed without underflow. If f_start == f_stop, fcw stays the same and wrap pulses.

Step event, dir down (mode 2 only):
- fcw > f_start: fcw <= max(fcw-step, f_start).
- fcw == f_start: dir <= up, fcw <= min(f_start+step, f_stop), wrap pulses.

Degenerate configuration:
- If f_start >= f_stop at latch, f_stop_eff = f_start. The sweep is a constant FCW; mode 0 ends after one dwell.

Timing:
- addr is combinational from the acc register, so it has 1-cycle latency from fcw to addr.
- sweep_done and wrap are registered, asserted in the cycle after the step-event edge.

Test Plan:
- Defaults, mode 0, f_start=100, f_stop=400, step=100, dwell=3; start at cycle 0 → fcw 100,200,300,400 for 3 cycles each (cycles 1–12); busy high cycles 1–12; sweep_done high cycle 13 only; fcw=0, busy=0 thereafter.
- Clamp: f_start=100, f_stop=350, step=100, dwell=1, mode 0 → fcw 100,200,300,350 then done; never 400.
- Mode 2, f_start=100, f_stop=300, step=100, dwell=1 → fcw 100,200,300,200,100,200,300,…; wrap pulses only after each return to 100; busy stays high.
- Accumulator wrap: f_start=f_stop=2^30, mode 1, dwell=1 → acc 0,2^30,2^31,3·2^30,0; addr 0,4096,8192,12288,0; wrap pulses every cycle.
- Abort: mode 1 running, stop asserted at cycle 7 → cycle 8 IDLE, fcw=0, addr=0, busy=0, no sweep_done; start and stop together in IDLE → stays IDLE.
- Edge config: dwell=0 and step=0 with f_start=5, f_stop=7, mode 0 → fcw 5,6,7, one cycle each, then sweep_done; async reset mid-sweep clears all outputs immediately, without waiting for a clock edge.
